// File: rtl/led_sweep_ctrl_if.sv
// Wishbone (pipelined) link between led_sweep_ctrl and the LED sweep peripheral.
// Member names keep the original port names so existing glue can map one-to-one.
interface led_sweep_ctrl_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [15:0] o_wb_addr;
  logic [15:0] o_wb_data;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic [15:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_stall, i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_stall, i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/led_sweep_ctrl.sv
// LED sweep sequencer: Wishbone master that starts a sweep with a write, polls
// the peripheral index field until it returns to 0, waits a gap and repeats.
// Optional bus timeout: define LED_SWEEP_CTRL_TIMEOUT_EN.
module led_sweep_ctrl #(
  parameter logic [15:0] LED_ADDR    = 16'h0000,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_count,
  input  logic [15:0]      i_gap,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_sweeps,
  output logic             o_err,
  led_sweep_ctrl_if.master wb
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WACK  = 3'd2,
    PWAIT = 3'd3,
    RD    = 3'd4,
    RACK  = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  count_q, count_nxt;
  logic [15:0] gap_q, gap_nxt;
  logic [7:0]  poll_cnt, poll_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]  sweeps_nxt;
  logic        done_nxt, err_nxt;
  logic        abort_pend, abort_nxt;
  logic        in_bus, in_bus_nxt;
  logic        timed_out;
  logic [3:0]  rd_index;
  logic [7:0]  sweeps_inc;
  logic        unused_rd_bits;

  assign in_bus     = (state == WR) || (state == WACK) || (state == RD) || (state == RACK);
  assign in_bus_nxt = (state_nxt == WR) || (state_nxt == WACK) ||
                      (state_nxt == RD) || (state_nxt == RACK);
  assign rd_index   = wb.i_wb_data[11:8];
  assign unused_rd_bits = ^{wb.i_wb_data[15:12], wb.i_wb_data[7:0]};
  assign sweeps_inc = o_sweeps + 8'd1;

  // Bus signals decode straight from state; stb only exists inside WR/RD, so never without cyc.
  assign o_busy       = (state != IDLE);
  assign wb.o_wb_cyc  = in_bus;
  assign wb.o_wb_stb  = (state == WR) || (state == RD);
  assign wb.o_wb_we   = (state == WR) || (state == WACK);
  assign wb.o_wb_addr = LED_ADDR;
  assign wb.o_wb_data = 16'h0001;

`ifdef LED_SWEEP_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign timed_out = in_bus && (to_cnt == TO_W'(TIMEOUT_CYC));

  // Strobe-to-ack cycle counter; restarts from 0 at every new strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (in_bus && in_bus_nxt) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0) || in_bus_nxt;
`endif

  // Next-state and datapath decisions.
  // Wait counters exit at 1 (or 0) so PWAIT/GAP last exactly N idle cycles;
  // a zero gap still spends one cycle in GAP so cyc drops between sweeps.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count_q;
    gap_nxt     = gap_q;
    poll_nxt    = poll_cnt;
    gap_cnt_nxt = gap_cnt;
    sweeps_nxt  = o_sweeps;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    abort_nxt   = abort_pend;

    if (in_bus && i_abort) begin
      abort_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (i_start) begin
          count_nxt  = i_count;
          gap_nxt    = i_gap;
          sweeps_nxt = '0;
          if (i_count == 8'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        if (!wb.i_wb_stall) begin
          state_nxt = WACK;
        end
      end
      WACK: begin
        if (wb.i_wb_ack) begin
          if (abort_pend || i_abort) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = PWAIT;
            poll_nxt  = 8'(POLL_GAP);
          end
        end
      end
      PWAIT: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (poll_cnt <= 8'd1) begin
          state_nxt = RD;
        end else begin
          poll_nxt = poll_cnt - 8'd1;
        end
      end
      RD: begin
        if (!wb.i_wb_stall) begin
          state_nxt = RACK;
        end
      end
      RACK: begin
        if (wb.i_wb_ack) begin
          if (abort_pend || i_abort) begin
            state_nxt = IDLE;
          end else if (rd_index != 4'd0) begin
            state_nxt = PWAIT;
            poll_nxt  = 8'(POLL_GAP);
          end else begin
            sweeps_nxt = sweeps_inc;
            if (sweeps_inc == count_q) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt   = GAP;
              gap_cnt_nxt = gap_q;
            end
          end
        end
      end
      GAP: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt <= 16'd1) begin
          state_nxt = WR;
        end else begin
          gap_cnt_nxt = gap_cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (timed_out) begin
      state_nxt  = IDLE;
      err_nxt    = 1'b1;
      done_nxt   = 1'b0;
      sweeps_nxt = o_sweeps;
      abort_nxt  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      count_q    <= '0;
      gap_q      <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      o_sweeps   <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_q    <= count_nxt;
      gap_q      <= gap_nxt;
      poll_cnt   <= poll_nxt;
      gap_cnt    <= gap_cnt_nxt;
      o_sweeps   <= sweeps_nxt;
      o_done     <= done_nxt;
      o_err      <= err_nxt;
      abort_pend <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed bench for led_sweep_ctrl with a small Wishbone slave model of the
// LED peripheral (programmable stall, ack gating and sweep length).
module tb_led_sweep_ctrl;
  localparam logic [15:0] ADDR = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  count = '0;
  logic [15:0] gap = '0;
  logic        busy, done, err;
  logic [7:0]  sweeps;

  int tests = 0;
  int fails = 0;

  led_sweep_ctrl_if wb ();

  led_sweep_ctrl #(.LED_ADDR(ADDR), .POLL_GAP(4), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_count(count),
    .i_gap(gap), .i_abort(abort), .o_busy(busy), .o_done(done),
    .o_sweeps(sweeps), .o_err(err), .wb(wb)
  );

  always #5 clk = ~clk;

  // Slave model: one outstanding transaction, ack one cycle after acceptance.
  int          stall_cnt = 0;
  bit          ack_en = 1'b1;
  int          sweep_len = 0;
  int          sweep_left = 0;
  bit          pend = 1'b0;
  bit          pend_we = 1'b0;
  logic        ack_q = 1'b0;
  logic [15:0] rdata = '0;

  assign wb.i_wb_stall = wb.o_wb_stb && (stall_cnt != 0);
  assign wb.i_wb_ack   = ack_q;
  assign wb.i_wb_data  = rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      ack_q      <= 1'b0;
      sweep_left <= 0;
    end else begin
      ack_q <= 1'b0;
      if (sweep_left != 0) sweep_left <= sweep_left - 1;
      if (pend && ack_en) begin
        ack_q <= 1'b1;
        pend  <= 1'b0;
        rdata <= {4'hF, (sweep_left != 0) ? 4'h3 : 4'h0, 8'hA5};
        if (pend_we) sweep_left <= sweep_len;
      end
      if (wb.o_wb_cyc && wb.o_wb_stb) begin
        if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
        else begin
          pend    <= 1'b1;
          pend_we <= wb.o_wb_we;
        end
      end
    end
  end

  // Bus/event monitor sampled on the falling edge.
  int wr_acc = 0, rd_acc = 0, done_cnt = 0, err_cnt = 0, cyc_cnt = 0;
  int idle_run = 0, last_wr_idle = 0, last_rd_idle = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (wb.o_wb_cyc) cyc_cnt++;
    if (wb.o_wb_cyc && wb.o_wb_stb && !wb.i_wb_stall) begin
      if (wb.o_wb_we) wr_acc++;
      else rd_acc++;
    end
    if (!wb.o_wb_cyc) idle_run++;
    else begin
      if (idle_run != 0 && wb.o_wb_stb) begin
        if (wb.o_wb_we) last_wr_idle = idle_run;
        else last_rd_idle = idle_run;
      end
      idle_run = 0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wr_acc = 0; rd_acc = 0; done_cnt = 0; err_cnt = 0; cyc_cnt = 0;
    last_wr_idle = 0; last_rd_idle = 0;
  endtask

  task automatic start_seq(input logic [7:0] c, input logic [15:0] g);
    count = c;
    gap = g;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick;
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic wait_wack(input string name);
    int n = 0;
    while (!(wb.o_wb_cyc && !wb.o_wb_stb && wb.o_wb_we) && n < 50) begin
      tick;
      n++;
    end
    tests++;
    if (!(wb.o_wb_cyc && !wb.o_wb_stb && wb.o_wb_we)) begin
      fails++;
      $display("FAIL %s_wack_reach: cyc=%0b stb=%0b we=%0b, want 1 0 1", name,
               wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we);
    end
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!wb.o_wb_stb && n < 50) begin
      tick;
      n++;
    end
    tests++;
    if (!wb.o_wb_stb) begin
      fails++;
      $display("FAIL %s_stb_reach: stb=%0b, want 1", name, wb.o_wb_stb);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    tests++;
    if ({busy, done, err, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, sweeps} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b cyc=%0b stb=%0b we=%0b sweeps=%0d, want all 0",
               busy, done, err, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, sweeps);
    end
    rst_n = 1'b1;
    tick;
    // Reset while the write ack is pending.
    ack_en = 1'b0;
    clear_mon;
    start_seq(8'd1, 16'd0);
    wait_wack("rst_mid");
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, sweeps} !== 14'd0) begin
      fails++;
      $display("FAIL reset_mid_wack: busy=%0b done=%0b err=%0b cyc=%0b stb=%0b we=%0b sweeps=%0d, want all 0",
               busy, done, err, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, sweeps);
    end
    tick;
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick;
    tests++;
    if (busy !== 1'b0 || wb.o_wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%0b cyc=%0b, want 0 0", busy, wb.o_wb_cyc);
    end
    sweep_len = 5;
    clear_mon;
    start_seq(8'd1, 16'd0);
    wait_idle(300, "rst_rerun");
    tests++;
    if (done_cnt !== 1 || sweeps !== 8'd1 || wr_acc !== 1) begin
      fails++;
      $display("FAIL reset_rerun: done_pulses=%0d sweeps=%0d writes=%0d, want 1 1 1",
               done_cnt, sweeps, wr_acc);
    end
  endtask

  task automatic test_two_sweeps;
    sweep_len = 60;
    clear_mon;
    start_seq(8'd2, 16'd3);
    repeat (10) tick;
    start_seq(8'd9, 16'd0);
    wait_idle(1000, "two_sweeps");
    tests++;
    if (wr_acc !== 2) begin
      fails++;
      $display("FAIL two_sweeps_writes: got %0d, want 2", wr_acc);
    end
    tests++;
    if (last_wr_idle !== 3) begin
      fails++;
      $display("FAIL two_sweeps_gap_idle: got %0d idle cycles, want 3", last_wr_idle);
    end
    tests++;
    if (last_rd_idle !== 4) begin
      fails++;
      $display("FAIL two_sweeps_poll_idle: got %0d idle cycles, want 4", last_rd_idle);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL two_sweeps_done: got %0d pulses, want 1", done_cnt);
    end
    tests++;
    if (sweeps !== 8'd2) begin
      fails++;
      $display("FAIL two_sweeps_count: got %0d, want 2", sweeps);
    end
  endtask

  task automatic test_zero_count;
    clear_mon;
    count = 8'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_done_pulse: done=%0b busy=%0b, want 1 0", done, busy);
    end
    tick;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL zero_done_single: done=%0b, want 0", done);
    end
    repeat (5) tick;
    tests++;
    if (cyc_cnt !== 0 || sweeps !== 8'd0 || done_cnt !== 1) begin
      fails++;
      $display("FAIL zero_no_bus: cyc_cycles=%0d sweeps=%0d done_pulses=%0d, want 0 0 1",
               cyc_cnt, sweeps, done_cnt);
    end
  endtask

  task automatic test_stall;
    stall_cnt = 5;
    sweep_len = 0;
    clear_mon;
    start_seq(8'd1, 16'd0);
    wait_stb("stall");
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (!(wb.o_wb_cyc && wb.o_wb_stb && wb.o_wb_we && wb.i_wb_stall) ||
          wb.o_wb_addr !== ADDR || wb.o_wb_data !== 16'h0001) begin
        fails++;
        $display("FAIL stall_hold_%0d: cyc=%0b stb=%0b we=%0b stall=%0b addr=%h data=%h, want 1 1 1 1 %h 0001",
                 i, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, wb.i_wb_stall,
                 wb.o_wb_addr, wb.o_wb_data, ADDR);
      end
      tick;
    end
    tests++;
    if (wb.o_wb_stb !== 1'b1 || wb.i_wb_stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_accept: stb=%0b stall=%0b, want 1 0", wb.o_wb_stb, wb.i_wb_stall);
    end
    tick;
    tests++;
    if (wb.o_wb_stb !== 1'b0 || wb.o_wb_cyc !== 1'b1) begin
      fails++;
      $display("FAIL stall_stb_drop: stb=%0b cyc=%0b, want 0 1", wb.o_wb_stb, wb.o_wb_cyc);
    end
    wait_idle(300, "stall");
    tests++;
    if (done_cnt !== 1 || wr_acc !== 1 || sweeps !== 8'd1) begin
      fails++;
      $display("FAIL stall_complete: done_pulses=%0d writes=%0d sweeps=%0d, want 1 1 1",
               done_cnt, wr_acc, sweeps);
    end
  endtask

  task automatic test_abort_gap;
    int n = 0;
    sweep_len = 8;
    clear_mon;
    start_seq(8'd3, 16'd20);
    while (!(sweeps == 8'd1 && busy && !wb.o_wb_cyc) && n < 500) begin
      tick;
      n++;
    end
    tests++;
    if (!(sweeps == 8'd1 && busy && !wb.o_wb_cyc)) begin
      fails++;
      $display("FAIL abort_gap_reach: sweeps=%0d busy=%0b cyc=%0b, want 1 1 0", sweeps, busy, wb.o_wb_cyc);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || wb.o_wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL abort_gap_idle: busy=%0b cyc=%0b, want 0 0", busy, wb.o_wb_cyc);
    end
    repeat (3) tick;
    tests++;
    if (done_cnt !== 0 || sweeps !== 8'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_gap_state: done_pulses=%0d sweeps=%0d busy=%0b, want 0 1 0",
               done_cnt, sweeps, busy);
    end
  endtask

  task automatic test_abort_wack;
    ack_en = 1'b0;
    sweep_len = 0;
    clear_mon;
    start_seq(8'd2, 16'd0);
    wait_wack("abort_wack");
    abort = 1'b1;
    tick;
    abort = 1'b0;
    repeat (3) tick;
    tests++;
    if (busy !== 1'b1 || wb.o_wb_cyc !== 1'b1) begin
      fails++;
      $display("FAIL abort_wack_hold: busy=%0b cyc=%0b, want 1 1", busy, wb.o_wb_cyc);
    end
    ack_en = 1'b1;
    tick;
    tests++;
    if (busy !== 1'b1 || wb.i_wb_ack !== 1'b1) begin
      fails++;
      $display("FAIL abort_wack_ackcycle: busy=%0b ack=%0b, want 1 1", busy, wb.i_wb_ack);
    end
    tick;
    tests++;
    if (busy !== 1'b0 || wb.o_wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL abort_wack_idle: busy=%0b cyc=%0b, want 0 0", busy, wb.o_wb_cyc);
    end
    tests++;
    if (done_cnt !== 0 || sweeps !== 8'd0 || wr_acc !== 1 || rd_acc !== 0) begin
      fails++;
      $display("FAIL abort_wack_state: done_pulses=%0d sweeps=%0d writes=%0d reads=%0d, want 0 0 1 0",
               done_cnt, sweeps, wr_acc, rd_acc);
    end
  endtask

`ifdef LED_SWEEP_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    ack_en = 1'b0;
    sweep_len = 0;
    clear_mon;
    start_seq(8'd1, 16'd0);
    wait_stb("timeout");
    for (int k = 1; k <= 8; k++) begin
      tick;
      tests++;
      if (wb.o_wb_cyc !== 1'b1 || err !== 1'b0) begin
        fails++;
        $display("FAIL timeout_wait_%0d: cyc=%0b err=%0b, want 1 0", k, wb.o_wb_cyc, err);
      end
    end
    tick;
    tests++;
    if (wb.o_wb_cyc !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: cyc=%0b err=%0b busy=%0b, want 0 1 0", wb.o_wb_cyc, err, busy);
    end
    tick;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_single: err=%0b, want 0", err);
    end
    ack_en = 1'b1;
    repeat (4) tick;
    tests++;
    if (busy !== 1'b0 || err_cnt !== 1 || done_cnt !== 0) begin
      fails++;
      $display("FAIL timeout_late_ack: busy=%0b err_pulses=%0d done_pulses=%0d, want 0 1 0",
               busy, err_cnt, done_cnt);
    end
  endtask
`else
  task automatic test_timeout;
    ack_en = 1'b0;
    sweep_len = 0;
    clear_mon;
    start_seq(8'd1, 16'd0);
    repeat (30) tick;
    tests++;
    if (wb.o_wb_cyc !== 1'b1 || busy !== 1'b1 || err_cnt !== 0) begin
      fails++;
      $display("FAIL no_timeout_wait: cyc=%0b busy=%0b err_pulses=%0d, want 1 1 0",
               wb.o_wb_cyc, busy, err_cnt);
    end
    ack_en = 1'b1;
    wait_idle(300, "no_timeout");
    tests++;
    if (done_cnt !== 1 || err_cnt !== 0 || sweeps !== 8'd1) begin
      fails++;
      $display("FAIL no_timeout_complete: done_pulses=%0d err_pulses=%0d sweeps=%0d, want 1 0 1",
               done_cnt, err_cnt, sweeps);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_two_sweeps;
    test_zero_count;
    test_stall;
    test_abort_gap;
    test_abort_wack;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns");
    $fatal(1);
  end

endmodule
